// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares one sync-read instruction memory between the loader and NUM_CORES fetch ports.
// Optional build macro IMEM_RELOAD_EN: dropping load_done while running returns the block to the load phase.
`default_nettype none

module imem_fetch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_we,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_done,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_we,
  output logic                        mem_re,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        loading
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(NUM_CORES - 1);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [NUM_CORES-1:0]   gnt_q;
  logic [NUM_CORES-1:0]   rvalid_q;
  logic                   mem_re_q;
  logic [ADDR_W-1:0]      faddr_q;

  logic [NUM_CORES-1:0]   eligible;
  logic                   any_elig;
  logic [PTR_W-1:0]       winner_idx;
  logic [NUM_CORES-1:0]   winner_oh;
  logic [ADDR_W-1:0]      winner_addr;
  logic [PTR_W-1:0]       ptr_d;
  int                     scan_idx;

  // A core granted this cycle is masked so it cannot win again while it drops req.
  assign eligible = req & ~gnt_q;

  always_comb begin
    any_elig    = 1'b0;
    winner_idx  = '0;
    winner_oh   = '0;
    winner_addr = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_CORES) scan_idx = scan_idx - NUM_CORES;
      if (!any_elig && eligible[scan_idx]) begin
        any_elig              = 1'b1;
        winner_idx            = PTR_W'(scan_idx);
        winner_oh[scan_idx]   = 1'b1;
        winner_addr           = req_addr[scan_idx*ADDR_W +: ADDR_W];
      end
    end
  end

  assign ptr_d = (winner_idx == LAST_CORE) ? '0 : winner_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_re_q <= 1'b0;
      faddr_q  <= '0;
    end else begin
      rvalid_q <= gnt_q;
      case (state_q)
        S_LOAD: begin
          gnt_q    <= '0;
          mem_re_q <= 1'b0;
          if (load_done) state_q <= S_RUN;
        end
        S_RUN: begin
`ifdef IMEM_RELOAD_EN
          if (!load_done) begin
            state_q  <= S_LOAD;
            gnt_q    <= '0;
            mem_re_q <= 1'b0;
            ptr_q    <= '0;
          end else
`endif
          if (any_elig) begin
            gnt_q    <= winner_oh;
            mem_re_q <= 1'b1;
            faddr_q  <= winner_addr;
            ptr_q    <= ptr_d;
          end else begin
            gnt_q    <= '0;
            mem_re_q <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign loading   = (state_q == S_LOAD);
  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign mem_re    = mem_re_q;
  // The loader keeps write enable high after its last store, so it is cut off in RUN.
  assign mem_we    = loading ? load_we : 1'b0;
  assign mem_addr  = loading ? load_addr : faddr_q;
  assign mem_wdata = load_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
// Testbench for imem_fetch_arbiter: vector table plus hand-written reset/reload sequences, with a read scoreboard.
`default_nettype none

module tb_imem_fetch_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_we;
  logic [7:0]   load_addr;
  logic [23:0]  load_data;
  logic         load_done;
  logic [3:0]   req;
  logic [31:0]  req_addr;
  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [23:0]  rdata;
  logic         mem_we;
  logic         mem_re;
  logic [7:0]   mem_addr;
  logic [23:0]  mem_wdata;
  logic [23:0]  mem_rdata;
  logic         loading;

  imem_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(24)) dut (
    .clk(clk), .reset(reset),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .req(req), .req_addr(req_addr), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .loading(loading)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read, one-cycle latency
  logic [23:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int          due;
    int          core;
    logic [23:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic        done;
    logic [3:0]  gnt;
    logic        loading;
  } vec_t;
  vec_t tbl[21];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam logic [31:0] A0 = 32'h03020100;
  localparam logic [31:0] A1 = 32'h07060504;

  function automatic logic [23:0] data_of(input logic [7:0] a);
    return 24'h010203 + ({16'h0, a} * 24'h010101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; pop the scoreboard when a read is due this cycle.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      chk("rvalid", {28'h0, rvalid}, 32'h1 << e.core);
      chk("rdata", {8'h0, rdata}, {8'h0, e.data});
    end else begin
      chk("rvalid_idle", {28'h0, rvalid}, 32'h0);
    end
  endtask

  task automatic apply(input logic [3:0] rq, input logic [31:0] ad, input logic dn,
                       input logic [3:0] eg, input logic el);
    int   idx;
    sb_t  e;
    idx = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
    req       = rq;
    req_addr  = ad;
    load_done = dn;
    if (eg != 4'b0000) begin
      e.due  = cyc + 2;
      e.core = idx;
      e.data = data_of(ad[idx*8 +: 8]);
      sb_q.push_back(e);
    end
    tick();
    chk("gnt", {28'h0, gnt}, {28'h0, eg});
    chk("mem_re", {31'h0, mem_re}, {31'h0, |eg});
    chk("loading", {31'h0, loading}, {31'h0, el});
    if (!el) chk("mem_we_run", {31'h0, mem_we}, 32'h0);
    if (eg != 4'b0000) chk("mem_addr", {24'h0, mem_addr}, {24'h0, ad[idx*8 +: 8]});
  endtask

  initial begin
    tbl[0]  = '{4'b1111, A0, 1'b1, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, A0, 1'b1, 4'b0001, 1'b0};
    tbl[2]  = '{4'b1111, A0, 1'b1, 4'b0010, 1'b0};
    tbl[3]  = '{4'b1111, A0, 1'b1, 4'b0100, 1'b0};
    tbl[4]  = '{4'b1111, A0, 1'b1, 4'b1000, 1'b0};
    tbl[5]  = '{4'b1111, A0, 1'b1, 4'b0001, 1'b0};
    tbl[6]  = '{4'b1111, A1, 1'b1, 4'b0010, 1'b0};
    tbl[7]  = '{4'b1111, A1, 1'b1, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1001, A1, 1'b1, 4'b1000, 1'b0};
    tbl[9]  = '{4'b1001, A1, 1'b1, 4'b0001, 1'b0};
    tbl[10] = '{4'b0000, A1, 1'b1, 4'b0000, 1'b0};
    tbl[11] = '{4'b0100, A1, 1'b1, 4'b0100, 1'b0};
    tbl[12] = '{4'b0100, A1, 1'b1, 4'b0000, 1'b0};
    tbl[13] = '{4'b0100, A1, 1'b1, 4'b0100, 1'b0};
    tbl[14] = '{4'b0100, A1, 1'b1, 4'b0000, 1'b0};
    tbl[15] = '{4'b0100, A1, 1'b1, 4'b0100, 1'b0};
    tbl[16] = '{4'b0000, A1, 1'b1, 4'b0000, 1'b0};
    tbl[17] = '{4'b0110, A0, 1'b1, 4'b0010, 1'b0};
    tbl[18] = '{4'b0110, A0, 1'b1, 4'b0100, 1'b0};
    tbl[19] = '{4'b0011, A0, 1'b1, 4'b0001, 1'b0};
    tbl[20] = '{4'b0000, A0, 1'b1, 4'b0000, 1'b0};

    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    load_done = 1'b0; req = 4'b0000; req_addr = '0;
    #1;
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_rvalid", {28'h0, rvalid}, 32'h0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h1);
    tick();
    tick();
    reset = 1'b0;

    // Load phase: writes pass through, requests are ignored
    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 8'(i); load_data = data_of(8'(i));
      req = 4'b1111; req_addr = A0;
      #1;
      chk("ld_mem_we", {31'h0, mem_we}, 32'h1);
      chk("ld_mem_addr", {24'h0, mem_addr}, i);
      chk("ld_mem_wdata", {8'h0, mem_wdata}, {8'h0, data_of(8'(i))});
      chk("ld_loading", {31'h0, loading}, 32'h1);
      tick();
      chk("ld_gnt", {28'h0, gnt}, 32'h0);
      chk("ld_mem_re", {31'h0, mem_re}, 32'h0);
    end
    load_we = 1'b0;

    // Run phase vectors; loader write enable stuck high after the transition
    load_addr = 8'h00; load_data = 24'hdeadbe;
    for (int i = 0; i < 21; i++) begin
      load_we = (i > 0);
      apply(tbl[i].req, tbl[i].addr, tbl[i].done, tbl[i].gnt, tbl[i].loading);
    end

    // Asynchronous reset right after a grant: the pending read is dropped
    apply(4'b0010, A0, 1'b1, 4'b0010, 1'b0);
    #1;
    reset = 1'b1;
    void'(sb_q.pop_back());
    #1;
    chk("amid_gnt", {28'h0, gnt}, 32'h0);
    chk("amid_mem_re", {31'h0, mem_re}, 32'h0);
    chk("amid_loading", {31'h0, loading}, 32'h1);
    load_we = 1'b0; req = 4'b0000;
    tick();
    reset = 1'b0;
    apply(4'b1111, A0, 1'b1, 4'b0000, 1'b0);
    apply(4'b1111, A0, 1'b1, 4'b0001, 1'b0);

    // Dropping load_done while running
`ifdef IMEM_RELOAD_EN
    apply(4'b1111, A0, 1'b0, 4'b0000, 1'b1);
    apply(4'b1111, A0, 1'b0, 4'b0000, 1'b1);
    apply(4'b1111, A0, 1'b1, 4'b0000, 1'b0);
    apply(4'b1111, A0, 1'b1, 4'b0001, 1'b0);
`else
    apply(4'b1111, A0, 1'b0, 4'b0010, 1'b0);
    apply(4'b1111, A0, 1'b0, 4'b0100, 1'b0);
    apply(4'b1111, A0, 1'b1, 4'b1000, 1'b0);
    apply(4'b1111, A0, 1'b1, 4'b0001, 1'b0);
`endif
    apply(4'b0000, A0, 1'b1, 4'b0000, 1'b0);
    apply(4'b0000, A0, 1'b1, 4'b0000, 1'b0);
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
